pwm_decoder: RTL and testbench

PWM_DECODER -- requirements
Module: pwm_decoder

---
 rtl/pwm_pkg.sv | 14 +
 rtl/pwm_div.sv | 71 +++++++
 rtl/pwm_decoder.sv | 186 ++++++++++++++++++
 tb/tb_pwm_decoder.sv | 196 +++++++++++++++++++
 4 files changed

// File: rtl/pwm_pkg.sv
// Shared types and default parameters for the PWM decoder.
package pwm_pkg;

    typedef enum logic [1:0] {
        WAIT_RISE = 2'd0,
        MEASURE   = 2'd1,
        DIVIDE    = 2'd2
    } pwm_state_e;

    localparam int unsigned PWM_R       = 8;
    localparam int unsigned PWM_CW      = 32;
    localparam int unsigned PWM_TIMEOUT = 2_500_000;

endpackage

// File: rtl/pwm_div.sv
// Sequential restoring divider: floor((dividend << R) / divisor), R+1
// quotient bits, one bit per clock after start. done is high during the
// cycle whose clock edge produces the final bit; quotient is valid then.
module pwm_div
    import pwm_pkg::*;
#(
    parameter int unsigned R  = PWM_R,
    parameter int unsigned CW = PWM_CW
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic          abort,
    input  logic [CW-1:0] dividend,
    input  logic [CW-1:0] divisor,
    output logic          done,
    output logic [R:0]    quotient
);

    localparam int unsigned     CNTW  = $clog2(R + 2);
    localparam logic [CNTW-1:0] ITERS = CNTW'(R + 1);
    localparam logic [CNTW-1:0] ONE   = CNTW'(1);
    localparam logic [R:0]      Q_MAX = {1'b1, {R{1'b0}}};

    logic            busy;
    logic [CW:0]     rem;
    logic [CW-1:0]   dvs;
    logic [R:0]      q;
    logic [CNTW-1:0] cnt;
    logic            ge;
    logic [CW-1:0]   diff;
    logic [R:0]      q_next;

    // One restoring step: the partial remainder stays below 2*divisor, so
    // shifting the dividend left by R is replaced by shifting the remainder.
    always_comb begin
        ge       = (rem >= {1'b0, dvs});
        diff     = ge ? CW'(rem - {1'b0, dvs}) : CW'(rem);
        q_next   = {q[R-1:0], ge};
        done     = busy && (cnt == ONE);
        quotient = (q_next > Q_MAX) ? Q_MAX : q_next;
    end

    // Operand load on start, then one quotient bit per cycle until done.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            busy <= 1'b0;
            rem  <= '0;
            dvs  <= '0;
            q    <= '0;
            cnt  <= '0;
        end else if (abort) begin
            busy <= 1'b0;
            cnt  <= '0;
        end else if (start) begin
            busy <= 1'b1;
            rem  <= {1'b0, dividend};
            dvs  <= divisor;
            q    <= '0;
            cnt  <= ITERS;
        end else if (busy) begin
            rem <= {diff, 1'b0};
            q   <= q_next;
            cnt <= cnt - ONE;
            if (cnt == ONE) begin
                busy <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/pwm_decoder.sv
// PWM decoder: measures period and high time of an asynchronous PWM input,
// reports duty as a fraction of 2^R, and flags a stuck input.
module pwm_decoder
    import pwm_pkg::*;
#(
    parameter int unsigned R       = PWM_R,
    parameter int unsigned CW      = PWM_CW,
    parameter int unsigned TIMEOUT = PWM_TIMEOUT
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          pwm_in,
    output logic [R:0]    duty,
    output logic [CW-1:0] period,
    output logic [CW-1:0] high_time,
    output logic          valid,
    output logic          stuck,
    output logic          overrun
);

    localparam logic [R:0]    DUTY_FULL = {1'b1, {R{1'b0}}};
    localparam logic [CW-1:0] CNT_ONE   = CW'(1);
    localparam logic [CW-1:0] CNT_MAX   = '1;
    localparam logic [CW-1:0] TO_LAST   = CW'(TIMEOUT - 1);

    pwm_state_e    state, state_next;
    logic          sync_1, sync_2, sync_3;
    logic          rise, fall, pin_edge;
    logic [CW-1:0] period_cnt, high_cnt, stuck_cnt;
    logic          fell_seen;
    logic          stuck_fire;
    logic [CW-1:0] op_period, op_high;
    logic          div_start, div_abort, div_done;
    logic [R:0]    div_q;
    logic          overrun_set, result_load;

    // Two-flop synchronizer plus one history flop for edge detection.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync_1 <= 1'b0;
            sync_2 <= 1'b0;
            sync_3 <= 1'b0;
        end else begin
            sync_1 <= pwm_in;
            sync_2 <= sync_1;
            sync_3 <= sync_2;
        end
    end

    // Edge strobes and the stuck-timeout trigger.
    always_comb begin
        rise       = sync_2 & ~sync_3;
        fall       = ~sync_2 & sync_3;
        pin_edge   = rise | fall;
        stuck_fire = !pin_edge && !stuck && (stuck_cnt == TO_LAST);
    end

    // FSM state register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= WAIT_RISE;
        end else begin
            state <= state_next;
        end
    end

    // FSM next-state logic; a stuck timeout overrides everything.
    always_comb begin
        state_next = state;
        if (stuck_fire) begin
            state_next = WAIT_RISE;
        end else begin
            unique case (state)
                WAIT_RISE: if (rise)     state_next = MEASURE;
                MEASURE:   if (rise)     state_next = DIVIDE;
                DIVIDE:    if (div_done) state_next = MEASURE;
                default:                 state_next = WAIT_RISE;
            endcase
        end
    end

    // FSM outputs; a rise during DIVIDE lets the running division finish.
    always_comb begin
        div_start   = (state == MEASURE) && rise;
        div_abort   = stuck_fire;
        overrun_set = (state == DIVIDE) && rise;
        result_load = (state == DIVIDE) && div_done && !stuck_fire;
    end

    // Saturating period and high-time counters, restarted at 1 on each rise.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            period_cnt <= '0;
            high_cnt   <= '0;
            fell_seen  <= 1'b0;
        end else if (rise) begin
            period_cnt <= CNT_ONE;
            high_cnt   <= CNT_ONE;
            fell_seen  <= 1'b0;
        end else begin
            if (fall) begin
                fell_seen <= 1'b1;
            end
            if (state != WAIT_RISE) begin
                if (period_cnt != CNT_MAX) begin
                    period_cnt <= period_cnt + CNT_ONE;
                end
                if (sync_2 && !fell_seen && (high_cnt != CNT_MAX)) begin
                    high_cnt <= high_cnt + CNT_ONE;
                end
            end
        end
    end

    // Hold the measured period and high time for reporting with the quotient.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            op_period <= '0;
            op_high   <= '0;
        end else if (div_start) begin
            op_period <= period_cnt;
            op_high   <= high_cnt;
        end
    end

    pwm_div #(
        .R  (R),
        .CW (CW)
    ) u_div (
        .clk      (clk),
        .rst      (rst),
        .start    (div_start),
        .abort    (div_abort),
        .dividend (high_cnt),
        .divisor  (period_cnt),
        .done     (div_done),
        .quotient (div_q)
    );

    // Cycles since the last edge; frozen once stuck until the next edge.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stuck_cnt <= '0;
            stuck     <= 1'b0;
        end else if (pin_edge) begin
            stuck_cnt <= '0;
            stuck     <= 1'b0;
        end else if (stuck_fire) begin
            stuck <= 1'b1;
        end else if (!stuck) begin
            stuck_cnt <= stuck_cnt + CNT_ONE;
        end
    end

    // Result registers with a single-cycle valid strobe.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            duty      <= '0;
            period    <= '0;
            high_time <= '0;
            valid     <= 1'b0;
        end else if (stuck_fire) begin
            duty      <= sync_2 ? DUTY_FULL : '0;
            period    <= '0;
            high_time <= '0;
            valid     <= 1'b1;
        end else if (result_load) begin
            duty      <= div_q;
            period    <= op_period;
            high_time <= op_high;
            valid     <= 1'b1;
        end else begin
            valid <= 1'b0;
        end
    end

    // Sticky overrun flag, cleared only by reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            overrun <= 1'b0;
        end else if (overrun_set) begin
            overrun <= 1'b1;
        end
    end

endmodule

// File: tb/tb_pwm_decoder.sv
// Directed bench for pwm_decoder: table-driven periodic waveforms plus
// hand-written stuck, overrun and mid-division reset sequences.
module tb_pwm_decoder;

    localparam int unsigned R       = 8;
    localparam int unsigned CW      = 10;
    localparam int unsigned TIMEOUT = 1000;

    logic          clk    = 1'b0;
    logic          rst    = 1'b1;
    logic          pwm_in = 1'b0;
    logic [R:0]    duty;
    logic [CW-1:0] period;
    logic [CW-1:0] high_time;
    logic          valid;
    logic          stuck;
    logic          overrun;

    always #5 clk = ~clk;

    pwm_decoder #(
        .R       (R),
        .CW      (CW),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .pwm_in    (pwm_in),
        .duty      (duty),
        .period    (period),
        .high_time (high_time),
        .valid     (valid),
        .stuck     (stuck),
        .overrun   (overrun)
    );

    typedef struct {
        int high;
        int per;
        int nper;
        int exp_duty;
        int exp_per;
        int exp_high;
    } vec_t;

    typedef struct {
        int it;
        int duty;
        int per;
        int hi;
    } ev_t;

    ev_t  log_q[$];
    int   it;
    int   checks = 0;
    int   errors = 0;
    vec_t vecs[6];

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Drive one input sample, advance one clock, sample #1 after the edge.
    task automatic step(input logic v);
        ev_t e;
        pwm_in = v;
        @(posedge clk);
        #1;
        if (valid) begin
            e.it   = it;
            e.duty = int'(duty);
            e.per  = int'(period);
            e.hi   = int'(high_time);
            log_q.push_back(e);
        end
        it++;
    endtask

    task automatic wave_steps(input int h, input int p, input int from, input int to);
        for (int i = from; i < to; i++) begin
            step((i % p) < h);
        end
    endtask

    task automatic do_reset(input bit check_zero);
        pwm_in = 1'b0;
        rst    = 1'b0;
        @(posedge clk);
        #1;
        if (check_zero) begin
            check("rst_duty", int'(duty), 0);
            check("rst_period", int'(period), 0);
            check("rst_high", int'(high_time), 0);
            check("rst_valid", int'(valid), 0);
            check("rst_stuck", int'(stuck), 0);
            check("rst_overrun", int'(overrun), 0);
        end
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        it  = 0;
        log_q.delete();
    endtask

    // Compare logged valid pulses against n evenly spaced expected results.
    task automatic check_log(input string name, input int n, input int first,
                             input int stride, input int d, input int p, input int h);
        check($sformatf("%s_count", name), log_q.size(), n);
        for (int k = 0; k < n && k < log_q.size(); k++) begin
            check($sformatf("%s[%0d]_cycle", name, k), log_q[k].it, first + k * stride);
            check($sformatf("%s[%0d]_duty", name, k), log_q[k].duty, d);
            check($sformatf("%s[%0d]_period", name, k), log_q[k].per, p);
            check($sformatf("%s[%0d]_high", name, k), log_q[k].hi, h);
        end
        log_q.delete();
    endtask

    initial begin
        // {high, period, periods, duty, period, high_time}
        vecs[0] = '{64, 256, 2, 64, 256, 64};
        vecs[1] = '{333, 1000, 3, 85, 1000, 333};
        vecs[2] = '{1, 300, 2, 0, 300, 1};
        vecs[3] = '{5, 10, 3, 128, 10, 5};
        vecs[4] = '{600, 1200, 1, 150, 1023, 600};
        vecs[5] = '{199, 200, 2, 254, 200, 199};

        do_reset(1'b1);

        // Periodic waveforms: first rise gives no result, valid 11 samples after each later rise.
        for (int v = 0; v < 6; v++) begin
            do_reset(1'b0);
            wave_steps(vecs[v].high, vecs[v].per, 0, vecs[v].nper * vecs[v].per + 12);
            check_log($sformatf("vec%0d", v), vecs[v].nper, vecs[v].per + 11, vecs[v].per,
                      vecs[v].exp_duty, vecs[v].exp_per, vecs[v].exp_high);
            check($sformatf("vec%0d_overrun", v), int'(overrun), 0);
            check($sformatf("vec%0d_stuck", v), int'(stuck), 0);
        end

        // Period 6: every other rise lands in DIVIDE.
        do_reset(1'b0);
        wave_steps(3, 6, 0, 13);
        check("ovr_before", int'(overrun), 0);
        wave_steps(3, 6, 13, 72);
        check("ovr_after", int'(overrun), 1);
        check_log("ovr", 5, 17, 12, 128, 6, 3);

        // Input stuck high, then released and measured again.
        do_reset(1'b0);
        for (int i = 0; i < 1020; i++) step(1'b1);
        check_log("stuck_hi", 1, 1002, 0, 256, 0, 0);
        check("stuck_set", int'(stuck), 1);
        step(1'b0);
        step(1'b0);
        check("stuck_hold", int'(stuck), 1);
        step(1'b0);
        check("stuck_clear", int'(stuck), 0);
        while (it < 1040) step(1'b0);
        for (int i = 0; i < 2 * 256 + 12; i++) step((i % 256) < 64);
        check_log("resume", 2, 1307, 256, 64, 256, 64);
        check("resume_stuck", int'(stuck), 0);

        // Reset asserted four cycles into a division.
        do_reset(1'b0);
        wave_steps(64, 256, 0, 518);
        check_log("pre_rst", 1, 267, 0, 64, 256, 64);
        check("pre_rst_duty", int'(duty), 64);
        rst = 1'b0;
        #1;
        check("mid_rst_duty", int'(duty), 0);
        check("mid_rst_period", int'(period), 0);
        check("mid_rst_high", int'(high_time), 0);
        check("mid_rst_valid", int'(valid), 0);
        check("mid_rst_stuck", int'(stuck), 0);
        check("mid_rst_overrun", int'(overrun), 0);
        wave_steps(64, 256, 518, 590);
        rst = 1'b1;
        wave_steps(64, 256, 590, 1037);
        check_log("post_rst", 1, 1035, 0, 64, 256, 64);

        // Input stuck low after a valid measurement.
        do_reset(1'b0);
        wave_steps(64, 256, 0, 582);
        check_log("lo_meas", 2, 267, 256, 64, 256, 64);
        for (int i = 0; i < 1100; i++) step(1'b0);
        check_log("stuck_lo", 1, 1578, 0, 0, 0, 0);
        check("stuck_lo_flag", int'(stuck), 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
